// File: rtl/vga_sync_recovery.sv
// Sink-side sync recovery: measures line/frame length from incoming hsync/vsync,
// rebuilds hpos/vpos tracking the source, and gates display_on on stable timing.
module vga_sync_recovery #(
  parameter int H_DISPLAY   = 640,
  parameter int V_DISPLAY   = 480,
  parameter int H_EDGE_POS  = 658,
  parameter int V_EDGE_POS  = 0,
  parameter int LOCK_LINES  = 4,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       display_on,
  output logic [9:0] h_total,
  output logic [9:0] v_total,
  output logic       h_locked,
  output logic       v_locked
);

  localparam int HLW = $clog2(LOCK_LINES + 1);
  localparam int VLW = $clog2(LOCK_FRAMES + 1);
  localparam logic [HLW-1:0] HLK_SAT = HLW'(LOCK_LINES);
  localparam logic [VLW-1:0] VLK_SAT = VLW'(LOCK_FRAMES);
  localparam logic [9:0]     CNT_SAT = 10'h3ff;

  logic           hs_q, vs_q, h_arm_q, v_arm_q;
  logic [9:0]     h_cnt_q, h_cnt_d, h_total_q, h_total_d;
  logic [9:0]     hpos_q, hpos_d, vpos_q, vpos_d;
  logic [9:0]     l_cnt_q, l_cnt_d, v_total_q, v_total_d;
  logic [HLW-1:0] hlk_q, hlk_d;
  logic [VLW-1:0] vlk_q, vlk_d;
  logic           h_rise, v_rise, h_wrap;
  logic [9:0]     h_len, v_len;

  // A sync already high out of reset must fall before its first edge counts.
  assign h_rise = hsync_in & ~hs_q & h_arm_q;
  assign v_rise = vsync_in & ~vs_q & v_arm_q;
  assign h_wrap = (h_total_q != 10'd0) && (hpos_q == h_total_q - 10'd1);
  assign h_len  = (h_cnt_q == CNT_SAT) ? 10'd0 : h_cnt_q + 10'd1;
  // The wrap on the capturing clock closes the ending frame, so it is counted.
  assign v_len  = (l_cnt_q == CNT_SAT) ? 10'd0 : l_cnt_q + {9'd0, h_wrap};

  always_comb begin
    h_cnt_d   = h_cnt_q;
    h_total_d = h_total_q;
    hlk_d     = hlk_q;
    hpos_d    = hpos_q;
    vpos_d    = vpos_q;
    l_cnt_d   = l_cnt_q;
    v_total_d = v_total_q;
    vlk_d     = vlk_q;

    if (h_rise) begin
      h_cnt_d   = 10'd0;
      h_total_d = h_len;
      if (h_len == h_total_q && h_len != 10'd0)
        hlk_d = (hlk_q == HLK_SAT) ? hlk_q : hlk_q + 1'b1;
      else
        hlk_d = HLW'(1);
    end else if (h_cnt_q == CNT_SAT) begin
      h_total_d = 10'd0;
      hlk_d     = '0;
    end else begin
      h_cnt_d = h_cnt_q + 10'd1;
    end

    if (h_rise)                  hpos_d = 10'(H_EDGE_POS);
    else if (h_wrap)             hpos_d = 10'd0;
    else if (hpos_q != CNT_SAT)  hpos_d = hpos_q + 10'd1;

    if (v_rise)                           vpos_d = 10'(V_EDGE_POS);
    else if (h_wrap && vpos_q != CNT_SAT) vpos_d = vpos_q + 10'd1;

    if (v_rise) begin
      l_cnt_d   = 10'd0;
      v_total_d = v_len;
    end else if (h_wrap && l_cnt_q != CNT_SAT) begin
      l_cnt_d = l_cnt_q + 10'd1;
    end

    // Frame lock restarts from scratch whenever line lock is lost.
    if (!h_locked)
      vlk_d = '0;
    else if (v_rise) begin
      if (v_len == v_total_q && v_len != 10'd0)
        vlk_d = (vlk_q == VLK_SAT) ? vlk_q : vlk_q + 1'b1;
      else
        vlk_d = VLW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      h_arm_q   <= 1'b0;
      v_arm_q   <= 1'b0;
      h_cnt_q   <= '0;
      h_total_q <= '0;
      hlk_q     <= '0;
      hpos_q    <= '0;
      vpos_q    <= '0;
      l_cnt_q   <= '0;
      v_total_q <= '0;
      vlk_q     <= '0;
    end else begin
      hs_q      <= hsync_in;
      vs_q      <= vsync_in;
      h_arm_q   <= h_arm_q | ~hsync_in;
      v_arm_q   <= v_arm_q | ~vsync_in;
      h_cnt_q   <= h_cnt_d;
      h_total_q <= h_total_d;
      hlk_q     <= hlk_d;
      hpos_q    <= hpos_d;
      vpos_q    <= vpos_d;
      l_cnt_q   <= l_cnt_d;
      v_total_q <= v_total_d;
      vlk_q     <= vlk_d;
    end
  end

  assign hpos       = hpos_q;
  assign vpos       = vpos_q;
  assign h_total    = h_total_q;
  assign v_total    = v_total_q;
  assign h_locked   = (hlk_q >= HLK_SAT);
  assign v_locked   = h_locked & (vlk_q >= VLK_SAT);
  assign display_on = h_locked & v_locked &
                      (hpos_q < 10'(H_DISPLAY)) & (vpos_q < 10'(V_DISPLAY));

endmodule

// File: tb/tb_vga_sync_recovery.sv
// Bench for vga_sync_recovery: small-raster loopback generator plus random sync,
// every cycle checked against a queue-based model of the measurement rules.
module tb_vga_sync_recovery;
  localparam int HD = 64, VD = 12, HS0 = 70, HE = 71, VE = 0, LL = 4, LF = 2;

  logic       clk = 1'b0, reset = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic [9:0] hpos, vpos, h_total, v_total;
  logic       display_on, h_locked, v_locked;

  vga_sync_recovery #(
    .H_DISPLAY(HD), .V_DISPLAY(VD), .H_EDGE_POS(HE), .V_EDGE_POS(VE),
    .LOCK_LINES(LL), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hpos(hpos), .vpos(vpos), .display_on(display_on), .h_total(h_total),
    .v_total(v_total), .h_locked(h_locked), .v_locked(v_locked)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: line/frame lengths kept as short histories; locked means the
  // most recent N measurements are all the same nonzero length.
  int m_hsp, m_vsp, m_since, m_htot, m_hpos, m_vpos, m_lines, m_vtot;
  int m_lh[$];
  int m_lv[$];

  function automatic bit m_hlk();
    if (m_lh.size() < LL) return 1'b0;
    foreach (m_lh[i]) if (m_lh[i] == 0 || m_lh[i] != m_lh[0]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_vlk();
    if (!m_hlk() || m_lv.size() < LF) return 1'b0;
    foreach (m_lv[i]) if (m_lv[i] == 0 || m_lv[i] != m_lv[0]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset();
    m_hsp = 1; m_vsp = 1;
    m_since = 0; m_htot = 0; m_hpos = 0; m_vpos = 0; m_lines = 0; m_vtot = 0;
    m_lh.delete(); m_lv.delete();
  endtask

  task automatic m_step(input bit hs, input bit vs);
    bit hl, hr, vr, wrap;
    int len, nv;
    hl   = m_hlk();
    hr   = hs && !m_hsp;
    vr   = vs && !m_vsp;
    wrap = (m_htot != 0) && (m_hpos == m_htot - 1);
    if (hr) begin
      len = (m_since == 1023) ? 0 : m_since + 1;
      m_lh.push_back(len);
      if (m_lh.size() > LL) void'(m_lh.pop_front());
      m_htot = len; m_since = 0;
    end else if (m_since == 1023) begin
      m_htot = 0; m_lh.delete();
    end else m_since++;
    if (hr) m_hpos = HE; else if (wrap) m_hpos = 0; else if (m_hpos < 1023) m_hpos++;
    if (vr) m_vpos = VE; else if (wrap && m_vpos < 1023) m_vpos++;
    if (!hl) m_lv.delete();
    if (vr) begin
      nv = (m_lines == 1023) ? 0 : m_lines + int'(wrap);
      if (hl) begin
        m_lv.push_back(nv);
        if (m_lv.size() > LF) void'(m_lv.pop_front());
      end
      m_vtot = nv; m_lines = 0;
    end else if (wrap && m_lines < 1023) m_lines++;
    m_hsp = hs; m_vsp = vs;
  endtask

  function automatic logic [63:0] m_outs();
    bit hl, vl;
    hl = m_hlk(); vl = m_vlk();
    return {21'd0, 10'(m_hpos), 10'(m_vpos), 10'(m_htot), 10'(m_vtot), hl, vl,
            hl && vl && m_hpos < HD && m_vpos < VD};
  endfunction

  function automatic logic [63:0] dut_outs();
    return {21'd0, hpos, vpos, h_total, v_total, h_locked, v_locked, display_on};
  endfunction

  // Loopback source: hsync rises at HS0, vsync rises on the last pixel of the frame.
  int g_h = 0, g_v = 0, gH = 80, gV = 16, hw = 6;
  bit gen_chk = 1'b0;

  function automatic bit g_hs();
    return g_h >= HS0 && g_h < HS0 + hw;
  endfunction

  function automatic bit g_vs();
    return (g_v == gV - 1 && g_h == gH - 1) || g_v < 2;
  endfunction

  task automatic tick(input bit hs, input bit vs, input bit adv);
    hsync_in = hs; vsync_in = vs;
    @(posedge clk);
    m_step(hs, vs);
    if (adv) begin
      g_h++;
      if (g_h >= gH) begin
        g_h = 0; g_v++;
        if (g_v >= gV) g_v = 0;
      end
    end
    @(negedge clk);
    chk("cycle", dut_outs(), m_outs());
    if (gen_chk)
      chk("loopback", {43'd0, hpos, vpos, display_on},
          {43'd0, 10'(g_h), 10'(g_v), g_h < HD && g_v < VD});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(g_hs(), g_vs(), 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("reset_outs", dut_outs(), 64'd0);
    m_reset();
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_locked(input string tag, input int ht);
    chk({tag, "_htot"}, 64'(h_total), 64'(ht));
    chk({tag, "_vtot"}, 64'(v_total), 64'(gV));
    chk({tag, "_locks"}, {62'd0, h_locked, v_locked}, 64'd3);
  endtask

  initial begin
    bit hs, vs;
    #1 do_reset();

    // Clean loopback from reset
    hw = $urandom_range(1, 8);
    run(155);   chk("htot_2nd_line", 64'(h_total), 64'd80);
    run(160);   chk("hlock_line3", 64'(h_locked), 64'd0);
    run(80);    chk("hlock_line4", 64'(h_locked), 64'd1);
    run(3 * 1280 + 5 - 395);
    chk_locked("frame3", 80);
    gen_chk = 1'b1; run(3 * 1280); gen_chk = 1'b0;

    // Line length jump 80 -> 81 mid-frame
    run(5 * 80 + 5);
    gH = 81;
    run(61 + 81);
    chk("jump_htot", 64'(h_total), 64'd81);
    chk("jump_hlock", 64'(h_locked), 64'd0);
    run(3 * 81); chk("jump_relock_h", 64'(h_locked), 64'd1);
    run(496 + 16 * 81 + 5);
    chk_locked("jump_relock", 81);
    gen_chk = 1'b1; run(16 * 81); gen_chk = 1'b0;

    // hsync missing for 1100 clocks
    for (int i = 0; i < 1100; i++) tick(1'b0, 1'b0, 1'b0);
    chk("timeout_outs", {60'd0, h_total == 10'd0, h_locked, v_locked, display_on}, 64'd8);
    g_h = 0; g_v = 0; gH = 80; hw = $urandom_range(1, 8);
    run(6 * 1280);
    chk_locked("timeout_relock", 80);

    // Async reset mid-frame, then relock from scratch
    run($urandom_range(3, 10) * 80 + $urandom_range(0, 79));
    do_reset();
    run(7 * 1280);
    chk_locked("reset_relock", 80);

    // Coincident vsync rise, hsync rise and hpos wrap
    for (int i = 0; i < 4000; i++) begin
      if (g_v == 7 && g_h == 79) break;
      run(1);
    end
    chk("inject_pos", 64'(g_v * 100 + g_h), 64'd779);
    tick(1'b1, 1'b1, 1'b1);
    chk("coinc_hpos", 64'(hpos), 64'(HE));
    chk("coinc_vpos", 64'(vpos), 64'(VE));
    chk("coinc_vtot", 64'(v_total), 64'd8);
    run(5 * 1280);
    chk_locked("coinc_relock", 80);

    // Wide hsync: one rise per line only
    gH = 300; hw = 200;
    run(8 * 300);
    for (int i = 0; i < 4; i++) begin
      chk("wide_htot", 64'(h_total), 64'd300);
      chk("wide_hlock", 64'(h_locked), 64'd1);
      run(300);
    end

    // Random sync activity with occasional async resets
    hs = 1'b0; vs = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) hs = ~hs;
      if ($urandom_range(0, 59) == 0) vs = ~vs;
      if ($urandom_range(0, 599) == 0) do_reset();
      tick(hs, vs, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
